fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//   Upstream configuration stage of the FIR digital_filter.
//   - Accepts a stream of NUM_TAPS coefficients over a valid/ready handshake into a shadow bank.
//   - Swaps the shadow bank into the active bank only on a filter sample boundary, so the
//     filter never sees a half-updated coefficient set.
//   - Drives the filter's coefficient input as a flattened bus.
// PARAMETERS
//   COEFF_WIDTH  16      width of one coefficient, two's complement Q1.15
//   NUM_TAPS     32      number of filter taps (>=2)
//   RESET_TAP0   16'h7FFF  active tap 0 after reset; all other taps reset to 0 (pass-through)
// PORTS
//   clk           in   1                     single clock, rising edge
//   rst           in   1                     asynchronous, active-high reset
//   cfg_valid     in   1                     cfg_data/cfg_last valid
//   cfg_ready     out  1                     loader can accept a word
//   cfg_data      in   COEFF_WIDTH           coefficient word; tap 0 first
//   cfg_last      in   1                     marks final word of a set
//   cfg_abort     in   1                     discard partial or pending set
//   sample_strobe in   1                     filter sample boundary; swaps are allowed only here
//   coeff_flat    out  NUM_TAPS*COEFF_WIDTH  active bank; tap i at [i*CW +: CW]
//   coeff_updated out  1                     1-cycle pulse, cycle after a swap
//   load_err      out  1                     1-cycle pulse on a framing error
//   pending       out  1                     full shadow set waiting for swap
// BEHAVIOUR
//   Reset (async): state=LOAD, idx=0, shadow=0.
//     Active bank: tap0=RESET_TAP0, all others 0.
//     cfg_ready=1; coeff_updated, load_err, pending = 0.
//   Transfer: a word transfers when cfg_valid && cfg_ready at the rising edge.
//     shadow[idx] <= cfg_data, then idx++.
//   State LOAD: cfg_ready=1.
//     - Transfer with idx==NUM_TAPS-1 && cfg_last -> state PEND, idx=0.
//     - Transfer with cfg_last && idx<NUM_TAPS-1 -> framing error.
//     - Transfer with idx==NUM_TAPS-1 && !cfg_last -> framing error.
//     - Framing error: load_err pulses next cycle, idx=0, state stays LOAD.
//       The active bank is untouched; stale shadow contents are overwritten by the next set.
//   State PEND: cfg_ready=0, pending=1.
//     - sample_strobe=1 -> active<=shadow at that edge; state LOAD.
//     - coeff_updated=1 for exactly the next cycle.
//   Same-cycle events:
//     - Final word accepted in the same cycle as sample_strobe: no swap in that cycle.
//       The swap waits for the next sample_strobe seen while in PEND.
//     - cfg_abort (any state): idx=0, state LOAD, pending=0, no load_err.
//       cfg_abort overrides a same-cycle transfer and a same-cycle swap.
//   Latency: coeff_flat changes exactly 1 clk after the qualifying sample_strobe edge.
//     coeff_flat is fully registered, with no combinational path from any input.
//   Reset mid-load or in PEND: partial/pending set lost; active bank returns to reset value.
//   cfg_ready depends only on state (no combinational dependence on cfg_valid).
// STRUCTURE
//   Package fir_pkg:
//     - COEFF_WIDTH, NUM_TAPS, DATA_WIDTH defaults.
//     - IDX_W = $clog2(NUM_TAPS).
//     - typedef enum {LOAD, PEND} ldr_state_t.
//     - coeff_t typedef.
//   Sub-module fir_coeff_bank:
//     - Shadow + active register arrays, indexed write port, swap input.
//     - Flattened active output.
//   This module holds the FSM, index counter and pulse logic.
// TESTING
//   1. Reset, no traffic -> coeff_flat tap0=16'h7FFF, taps1..31=0; cfg_ready=1, pending=0.
//   2. Load words 1..32 (last on 32nd), sample_strobe 5 cycles later
//      -> pending=1 until strobe; tap i=i+1 one cycle after strobe; coeff_updated pulses once.
//   3. cfg_last on 10th word -> load_err pulse; coeff_flat unchanged.
//      Then a full valid set of 32 loads correctly.
//   4. 32nd word without cfg_last -> load_err; idx=0; no PEND.
//   5. Final word and sample_strobe in same cycle -> no swap.
//      Swap on the next strobe; coeff_updated cycle after that.
//   6. Assert rst while in PEND with a set of 16'h1234 -> active returns to reset pattern,
//      pending=0, cfg_ready=1.
//      Also: cfg_abort in PEND with sample_strobe high -> no swap, no coeff_updated.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader and its coefficient bank.
// Provides the default sizes, the loader state encoding and the coefficient type.
package fir_pkg;

  localparam int unsigned          DEF_COEFF_WIDTH = 16;
  localparam int unsigned          DEF_NUM_TAPS    = 32;
  localparam int unsigned          DEF_DATA_WIDTH  = 16;
  localparam int unsigned          IDX_W           = $clog2(DEF_NUM_TAPS);
  localparam logic [15:0]          DEF_RESET_TAP0  = 16'h7FFF;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    PEND = 1'b1
  } ldr_state_t;

  typedef logic [DEF_COEFF_WIDTH-1:0] coeff_t;

endpackage : fir_pkg

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient register banks.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   wr_en       write wr_data into shadow[wr_idx]
//   wr_idx      shadow write index
//   wr_data     coefficient to write
//   swap        copy the whole shadow bank into the active bank
//   coeff_flat  active bank, tap i at [i*COEFF_WIDTH +: COEFF_WIDTH]
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned                  COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned                  NUM_TAPS    = DEF_NUM_TAPS,
  parameter logic [COEFF_WIDTH-1:0]       RESET_TAP0  = COEFF_WIDTH'(DEF_RESET_TAP0),
  parameter int unsigned                  IW          = $clog2(NUM_TAPS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [IW-1:0]                   wr_idx,
  input  logic [COEFF_WIDTH-1:0]          wr_data,
  input  logic                            swap,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat
);

  logic [COEFF_WIDTH-1:0] shadow_q [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] shadow_d [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] active_q [NUM_TAPS];
  logic [COEFF_WIDTH-1:0] active_d [NUM_TAPS];

  // Next-state for both banks; a swap takes the shadow contents as they stood before this edge.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) begin
      shadow_d[wr_idx] = wr_data;
    end
    if (swap) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= (i == 0) ? RESET_TAP0 : '0;
      end
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Flatten the active bank; pure wiring of register outputs.
  always_comb begin
    coeff_flat = '0;
    for (int i = 0; i < int'(NUM_TAPS); i++) begin
      coeff_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[i];
    end
  end

endmodule : fir_coeff_bank

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: collects a full coefficient set into a shadow bank over a
// valid/ready stream and swaps it into the active bank only on a sample boundary.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   cfg_valid/ready/data/last  coefficient stream, tap 0 first, last on final tap
//   cfg_abort      discard any partial or pending set
//   sample_strobe  filter sample boundary; the only point where a swap may happen
//   coeff_flat     active coefficients to the filter
//   coeff_updated  1-cycle pulse the cycle after a swap
//   load_err       1-cycle pulse after a framing error
//   pending        a complete set is waiting for a sample boundary
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int unsigned                  COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned                  NUM_TAPS    = DEF_NUM_TAPS,
  parameter logic [COEFF_WIDTH-1:0]       RESET_TAP0  = COEFF_WIDTH'(DEF_RESET_TAP0)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [COEFF_WIDTH-1:0]          cfg_data,
  input  logic                            cfg_last,
  input  logic                            cfg_abort,
  input  logic                            sample_strobe,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_flat,
  output logic                            coeff_updated,
  output logic                            load_err,
  output logic                            pending
);

  localparam int unsigned IW = $clog2(NUM_TAPS);

  ldr_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cfg_ready_q, cfg_ready_d;
  logic          pending_q, pending_d;
  logic          coeff_updated_q, coeff_updated_d;
  logic          load_err_q, load_err_d;
  logic          xfer_c;
  logic          wr_en_c;
  logic          swap_c;
  logic          last_idx_c;

  // Handshake qualifiers; abort suppresses both the shadow write and the swap.
  always_comb begin
    xfer_c     = cfg_valid && cfg_ready_q;
    wr_en_c    = xfer_c && !cfg_abort;
    swap_c     = (state_q == PEND) && sample_strobe && !cfg_abort;
    last_idx_c = (idx_q == IW'(NUM_TAPS - 1));
  end

  // Next-state, index and pulse logic.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    load_err_d      = 1'b0;
    coeff_updated_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (xfer_c) begin
          if (last_idx_c && cfg_last) begin
            state_d = PEND;
            idx_d   = '0;
          end else if (last_idx_c || cfg_last) begin
            // Framing error: restart the set, active bank untouched.
            load_err_d = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PEND: begin
        if (sample_strobe) begin
          state_d         = LOAD;
          coeff_updated_d = 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase

    if (cfg_abort) begin
      state_d         = LOAD;
      idx_d           = '0;
      load_err_d      = 1'b0;
      coeff_updated_d = 1'b0;
    end

    // Status outputs are registered copies of the next state.
    cfg_ready_d = (state_d == LOAD);
    pending_d   = (state_d == PEND);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= LOAD;
      idx_q           <= '0;
      cfg_ready_q     <= 1'b1;
      pending_q       <= 1'b0;
      coeff_updated_q <= 1'b0;
      load_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cfg_ready_q     <= cfg_ready_d;
      pending_q       <= pending_d;
      coeff_updated_q <= coeff_updated_d;
      load_err_q      <= load_err_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign pending       = pending_q;
  assign coeff_updated = coeff_updated_q;
  assign load_err      = load_err_q;

  fir_coeff_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS),
    .RESET_TAP0  (RESET_TAP0),
    .IW          (IW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en_c),
    .wr_idx     (idx_q),
    .wr_data    (cfg_data),
    .swap       (swap_c),
    .coeff_flat (coeff_flat)
  );

endmodule : fir_coeff_loader

// File: tb/tb_fir_coeff_loader.sv
// Directed testbench for fir_coeff_loader with 32 taps of 16 bits.
module tb_fir_coeff_loader;

  localparam int unsigned CW = 16;
  localparam int unsigned NT = 32;
  localparam int unsigned FW = NT * CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_data;
  logic          cfg_last;
  logic          cfg_abort;
  logic          sample_strobe;
  logic [FW-1:0] coeff_flat;
  logic          coeff_updated;
  logic          load_err;
  logic          pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] rst_flat;
  logic [FW-1:0] exp_flat;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .COEFF_WIDTH (CW),
    .NUM_TAPS    (NT),
    .RESET_TAP0  (16'h7FFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_data      (cfg_data),
    .cfg_last      (cfg_last),
    .cfg_abort     (cfg_abort),
    .sample_strobe (sample_strobe),
    .coeff_flat    (coeff_flat),
    .coeff_updated (coeff_updated),
    .load_err      (load_err),
    .pending       (pending)
  );

  // Expected bus with tap i = base + i*step.
  function automatic logic [FW-1:0] make_flat(input int base, input int step);
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < int'(NT); i++) begin
      f[i*CW +: CW] = CW'(base + i * step);
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n words back to back; counts load_err pulses seen after each edge.
  task automatic load_set(input int base, input int step, input int n, input int last_at,
                          input bit strobe_on_last, output int errs);
    errs = 0;
    for (int k = 0; k < n; k++) begin
      cfg_valid     = 1'b1;
      cfg_data      = CW'(base + k * step);
      cfg_last      = (k == last_at);
      sample_strobe = strobe_on_last && (k == n - 1);
      tick();
      if (load_err === 1'b1) errs++;
    end
    cfg_valid     = 1'b0;
    cfg_last      = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic pulse_strobe();
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (coeff_flat !== rst_flat) begin
      n_fail++;
      $display("FAIL reset_coeff: got %h expected %h", coeff_flat, rst_flat);
    end
    n_checks++;
    if ({cfg_ready, pending, coeff_updated, load_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_status: got rdy/pend/upd/err=%b expected 1000",
               {cfg_ready, pending, coeff_updated, load_err});
    end
  endtask

  task automatic test_load_swap();
    int errs;
    load_set(1, 1, 32, 31, 1'b0, errs);
    n_checks++;
    if ({pending, cfg_ready, errs != 0} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_pend: got pend/rdy/err=%b expected 100", {pending, cfg_ready, errs != 0});
    end
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (pending !== 1'b1 || coeff_updated !== 1'b0 || coeff_flat !== rst_flat) begin
      n_fail++;
      $display("FAIL load_wait: got pend=%b upd=%b coeff=%h expected pend=1 upd=0 reset bank",
               pending, coeff_updated, coeff_flat);
    end
    pulse_strobe();
    exp_flat = make_flat(1, 1);
    n_checks++;
    if (coeff_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL load_swap_coeff: got %h expected %h", coeff_flat, exp_flat);
    end
    n_checks++;
    if ({coeff_updated, pending, cfg_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL load_swap_status: got upd/pend/rdy=%b expected 101",
               {coeff_updated, pending, cfg_ready});
    end
    tick();
    n_checks++;
    if (coeff_updated !== 1'b0) begin
      n_fail++;
      $display("FAIL load_upd_once: got %b expected 0", coeff_updated);
    end
  endtask

  task automatic test_early_last();
    int errs;
    load_set(16'h0100, 1, 10, 9, 1'b0, errs);
    n_checks++;
    if (errs !== 1 || pending !== 1'b0 || coeff_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL early_last: got errs=%0d pend=%b coeff=%h expected errs=1 pend=0 coeff=%h",
               errs, pending, coeff_flat, exp_flat);
    end
    tick();
    n_checks++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL early_last_pulse: got %b expected 0", load_err);
    end
    load_set(16'h0200, 3, 32, 31, 1'b0, errs);
    pulse_strobe();
    exp_flat = make_flat(16'h0200, 3);
    n_checks++;
    if (errs !== 0 || coeff_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL early_last_reload: got errs=%0d coeff=%h expected errs=0 coeff=%h",
               errs, coeff_flat, exp_flat);
    end
  endtask

  task automatic test_missing_last();
    int errs;
    load_set(16'h0400, 1, 32, -1, 1'b0, errs);
    n_checks++;
    if (errs !== 1 || pending !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL missing_last: got errs=%0d pend=%b rdy=%b expected errs=1 pend=0 rdy=1",
               errs, pending, cfg_ready);
    end
    // A fresh set must land at tap 0 again.
    load_set(16'h8000, 16'h11, 32, 31, 1'b0, errs);
    pulse_strobe();
    exp_flat = make_flat(16'h8000, 16'h11);
    n_checks++;
    if (errs !== 0 || coeff_flat !== exp_flat) begin
      n_fail++;
      $display("FAIL missing_last_reload: got errs=%0d coeff=%h expected errs=0 coeff=%h",
               errs, coeff_flat, exp_flat);
    end
  endtask

  task automatic test_same_cycle_strobe();
    int errs;
    logic [FW-1:0] prev;
    prev = exp_flat;
    load_set(16'hF000, 2, 32, 31, 1'b1, errs);
    n_checks++;
    if (pending !== 1'b1 || coeff_updated !== 1'b0 || coeff_flat !== prev) begin
      n_fail++;
      $display("FAIL same_cycle_noswap: got pend=%b upd=%b coeff=%h expected pend=1 upd=0 coeff=%h",
               pending, coeff_updated, coeff_flat, prev);
    end
    tick();
    tick();
    pulse_strobe();
    exp_flat = make_flat(16'hF000, 2);
    n_checks++;
    if (coeff_flat !== exp_flat || coeff_updated !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_swap: got upd=%b coeff=%h expected upd=1 coeff=%h",
               coeff_updated, coeff_flat, exp_flat);
    end
  endtask

  task automatic test_reset_in_pend();
    int errs;
    load_set(16'h1234, 0, 32, 31, 1'b0, errs);
    n_checks++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pend_setup: got pend=%b expected 1", pending);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (coeff_flat !== rst_flat || pending !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_pend: got pend=%b rdy=%b coeff=%h expected pend=0 rdy=1 coeff=%h",
               pending, cfg_ready, coeff_flat, rst_flat);
    end
    tick();
    rst = 1'b0;
    tick();
    pulse_strobe();
    n_checks++;
    if (coeff_flat !== rst_flat || coeff_updated !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_set_lost: got upd=%b coeff=%h expected upd=0 coeff=%h",
               coeff_updated, coeff_flat, rst_flat);
    end
  endtask

  task automatic test_abort();
    int errs;
    load_set(16'h5555, 0, 32, 31, 1'b0, errs);
    cfg_abort     = 1'b1;
    sample_strobe = 1'b1;
    tick();
    cfg_abort     = 1'b0;
    sample_strobe = 1'b0;
    n_checks++;
    if (coeff_flat !== rst_flat || coeff_updated !== 1'b0 || pending !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pend: got upd=%b pend=%b rdy=%b coeff=%h expected upd=0 pend=0 rdy=1 coeff=%h",
               coeff_updated, pending, cfg_ready, coeff_flat, rst_flat);
    end
    // Abort midway through a set; the transfer in the abort cycle is discarded too.
    load_set(16'h0900, 1, 5, -1, 1'b0, errs);
    cfg_valid = 1'b1;
    cfg_data  = 16'hDEAD;
    cfg_abort = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_abort = 1'b0;
    n_checks++;
    if (load_err !== 1'b0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_mid: got err=%b pend=%b expected 0 0", load_err, pending);
    end
    load_set(16'h0A00, 5, 32, 31, 1'b0, errs);
    pulse_strobe();
    exp_flat = make_flat(16'h0A00, 5);
    n_checks++;
    if (errs !== 0 || coeff_flat !== exp_flat || coeff_updated !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reload: got errs=%0d upd=%b coeff=%h expected errs=0 upd=1 coeff=%h",
               errs, coeff_updated, coeff_flat, exp_flat);
    end
  endtask

  initial begin
    rst           = 1'b1;
    cfg_valid     = 1'b0;
    cfg_data      = '0;
    cfg_last      = 1'b0;
    cfg_abort     = 1'b0;
    sample_strobe = 1'b0;
    rst_flat      = '0;
    rst_flat[CW-1:0] = 16'h7FFF;
    exp_flat      = rst_flat;

    test_reset();
    test_load_swap();
    test_early_last();
    test_missing_last();
    test_same_cycle_strobe();
    test_reset_in_pend();
    test_abort();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fir_coeff_loader
